hms_countdown: RTL

Hours/minutes/seconds countdown timer for the clock display path. It is the decrementing counterpart of the 60-second up-counter chain. The block takes a loaded start time and counts down one second per `tick` pulse, borrowing across seconds, minutes and hours. When the count reaches 00:00:00 it raises a one-cycle `done` pulse and a held `alarm` level. It sits beside the time-of-day counters and shares their 1 Hz tick and their display encoding.

---
 rtl/countdown_pkg.sv | 13 +
 rtl/mod60_down.sv | 34 +++
 rtl/hms_countdown.sv | 123 ++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and limits for the hours/minutes/seconds countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [6:0] SEC_MAX = 7'd59;
    localparam logic [6:0] MIN_MAX = 7'd59;

    function automatic logic [6:0] clamp_to(input logic [6:0] v, input logic [6:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/mod60_down.sv
// Loadable modulo-60 down counter; borrows (wraps 0 -> 59) when enabled at zero.
module mod60_down
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [6:0] value,
    output logic       borrow
);

    logic [6:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load)
            value_d = load_val;
        else if (en)
            value_d = (value_q == 7'd0) ? SEC_MAX : value_q - 7'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            value_q <= 7'd0;
        else
            value_q <= value_d;
    end

    assign value  = value_q;
    assign borrow = en && (value_q == 7'd0);

endmodule

// File: rtl/hms_countdown.sv
// Hours/minutes/seconds countdown timer: load, start/pause/resume, done pulse
// and held alarm when the count reaches 00:00:00.
module hms_countdown
    import countdown_pkg::*;
#(
    parameter int MAX_HOURS = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [4:0] load_h,
    input  logic [6:0] load_m,
    input  logic [6:0] load_s,
    input  logic       start,
    input  logic       pause,
    output logic [4:0] hours,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [4:0] HOURS_LIM = 5'(MAX_HOURS);

    state_t     state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;

    logic       dec;
    logic       sec_borrow, min_borrow;
    logic [6:0] sec_val, min_val;
    logic       nonzero, at_one;

    assign nonzero = (hours_q != 5'd0) || (min_val != 7'd0) || (sec_val != 7'd0);
    assign at_one  = (hours_q == 5'd0) && (min_val == 7'd0) && (sec_val == 7'd1);

    mod60_down u_sec (
        .clk      (clk),
        .reset    (reset),
        .en       (dec),
        .load     (load),
        .load_val (clamp_to(load_s, SEC_MAX)),
        .value    (sec_val),
        .borrow   (sec_borrow)
    );

    mod60_down u_min (
        .clk      (clk),
        .reset    (reset),
        .en       (sec_borrow),
        .load     (load),
        .load_val (clamp_to(load_m, MIN_MAX)),
        .value    (min_val),
        .borrow   (min_borrow)
    );

    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (start && nonzero) state_d = RUN;
                RUN: begin
                    // pause outranks tick; a tick alongside pause is dropped
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        dec = 1'b1;
                        if (at_one) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: if (start) state_d = RUN;
                DONE:  if (start) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hours_d = hours_q;
        if (load)
            hours_d = (load_h > HOURS_LIM) ? HOURS_LIM : load_h;
        else if (min_borrow)
            hours_d = hours_q - 5'd1;
    end

    assign running_d = (state_d == RUN);
    assign alarm_d   = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hours_q   <= 5'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign hours   = hours_q;
    assign minutes = min_val;
    assign seconds = sec_val;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule
